// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory port.
// TXDATA stores feed a small byte FIFO. A baud FSM drains it onto tx.
// STATUS and DIVISOR read back combinationally so loads never stall the core.
// Handshake: the FIFO push side has no back-pressure. A TXDATA store is
// accepted only when count < FIFO_DEPTH before the edge. Otherwise it is
// dropped and the sticky overflow flag is set. The pop side is internal:
// the FSM pops exactly when it sits in IDLE and the FIFO is non-empty.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_enable,
  input  logic [2:0]  io_width,
  input  logic [31:0] io_address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        tx_idle
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Address decode.
  logic       sel;
  logic [1:0] offset;
  assign sel    = (io_address[31:4] == BASE_ADDR[31:4]);
  assign offset = io_address[3:2];

  logic wr_txdata, wr_status, wr_divisor;
  assign wr_txdata  = write_enable && sel && (offset == 2'd0);
  assign wr_status  = write_enable && sel && (offset == 2'd1);
  assign wr_divisor = write_enable && sel && (offset == 2'd2);

  // FIFO storage and bookkeeping.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push_ok, pop;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = wr_txdata && !full;

  // Registers visible to software.
  logic        overflow_q;
  logic [15:0] divisor_q;

  // FSM state and datapath registers. state_q is the debug-visible state.
  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] bit_period_q, bit_period_d;
  logic        tx_q, tx_d;
  logic        tx_idle_q, tx_idle_d;
  logic        baud_done;

  assign baud_done = (baud_q == bit_period_q - 16'd1);

  // Next FIFO occupancy; a full FIFO with a pop still drops the push.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, count and storage write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // FIFO data array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in[7:0];
  end

  // Sticky overflow flag and divisor register.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      divisor_q  <= DEFAULT_DIVISOR;
    end else begin
      if (wr_txdata && full)            overflow_q <= 1'b1;
      else if (wr_status && data_in[3]) overflow_q <= 1'b0;
      if (wr_divisor) begin
        if (io_width == 3'b000) divisor_q[7:0] <= data_in[7:0];
        else                    divisor_q      <= data_in[15:0];
      end
    end
  end

  // FSM next state; tx_d is the line level for the state being entered.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    baud_d       = baud_q;
    bit_period_d = bit_period_q;
    tx_d         = 1'b1;
    pop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          shift_d      = mem[rd_ptr];
          bit_period_d = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
          baud_d       = 16'd0;
          state_d      = S_START;
          tx_d         = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = 16'd0;
          idx_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
          tx_d   = 1'b0;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
          tx_d   = shift_q[0];
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_d  = 16'd0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    tx_idle_d = (state_d == S_IDLE) && (count_d == '0);
  end

  // FSM and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= 8'd0;
      idx_q        <= 3'd0;
      baud_q       <= 16'd0;
      bit_period_q <= 16'd0;
      tx_q         <= 1'b1;
      tx_idle_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      baud_q       <= baud_d;
      bit_period_q <= bit_period_d;
      tx_q         <= tx_d;
      tx_idle_q    <= tx_idle_d;
    end
  end

  assign tx      = tx_q;
  assign tx_idle = tx_idle_q;

  // Combinational load data.
  logic [7:0]  count8;
  logic [31:0] status_word;
  logic        busy;
  assign busy        = (state_q != S_IDLE);
  assign count8      = 8'(count_q);
  assign status_word = {16'h0000, count8, 4'h0, overflow_q, busy, empty, full};

  // Load mux; zero outside the window and for write-only/reserved offsets.
  always_comb begin
    data_out = 32'h0;
    if (sel) begin
      case (offset)
        2'd1:    data_out = status_word;
        2'd2:    data_out = {16'h0000, divisor_q};
        default: data_out = 32'h0;
      endcase
    end
  end

  // Store bits and address bits that no register consumes.
  logic unused_bits;
  assign unused_bits = ^{data_in[31:16], io_address[1:0]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, FIFO fill,
// overflow, divisor handling, reset abort and address decode.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_enable = 1'b0;
  logic [2:0]  io_width = 3'b010;
  logic [31:0] io_address = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        tx;
  logic        tx_idle;

  int checks = 0;
  int failures = 0;

  logic [1:0] exp_q[$];
  logic [1:0] cap_q[$];

  mmio_uart_tx #(
    .BASE_ADDR(32'h1000_0000),
    .FIFO_DEPTH(4),
    .DEFAULT_DIVISOR(16'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write_enable(write_enable),
    .io_width(io_width),
    .io_address(io_address),
    .data_in(data_in),
    .data_out(data_out),
    .tx(tx),
    .tx_idle(tx_idle)
  );

  // Clock and safety timeout.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  // Driver: one store, returns 1 time unit after the edge that samples it.
  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] width);
    @(negedge clk);
    io_address   = addr;
    data_in      = data;
    io_width     = width;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  // Driver: combinational load.
  task automatic read_reg(input logic [31:0] addr, output logic [31:0] d);
    io_address = addr;
    #1;
    d = data_out;
  endtask

  // Monitor: sample {tx, tx_idle} once per clock, n samples.
  task automatic capture(input int n);
    cap_q.delete();
    for (int i = 0; i < n; i++) begin
      cap_q.push_back({tx, tx_idle});
      @(posedge clk);
      #1;
    end
  endtask

  // Expected line samples for one 8N1 frame, optionally plus the idle gap clock.
  function automatic void add_frame(input logic [7:0] b, input int bp, input bit gap);
    logic v;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = 1'b1;
      else             v = b[k-1];
      for (int c = 0; c < bp; c++) exp_q.push_back({v, 1'b0});
    end
    if (gap) exp_q.push_back(2'b10);
  endfunction

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    read_reg(32'h1000_0004, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL reset_status: got %h expected %h", d, 32'h0000_0002);
    end
    checks++;
    if ({tx, tx_idle} !== 2'b11) begin
      failures++;
      $display("FAIL reset_lines: {tx,tx_idle}=%b expected 11", {tx, tx_idle});
    end
    read_reg(32'h1000_0008, d);
    checks++;
    if (d !== 32'h0000_0010) begin
      failures++;
      $display("FAIL reset_divisor: got %h expected %h", d, 32'h0000_0010);
    end
    read_reg(32'h1000_0000, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL txdata_reads_zero: got %h expected 0", d);
    end
  endtask

  task automatic test_frame;
    int bad;
    store(32'h1000_0008, 32'h0000_0004, 3'b010);
    store(32'h1000_0000, 32'h0000_0055, 3'b000);
    exp_q.delete();
    exp_q.push_back(2'b10);
    add_frame(8'h55, 4, 1'b0);
    exp_q.push_back(2'b11);
    capture(exp_q.size());
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL frame_55_div4: sample %0d {tx,tx_idle}=%b expected %b",
               bad, cap_q[bad], exp_q[bad]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d1, d2;
    logic [7:0] bytes [5];
    int bad;
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
    bytes[3] = 8'h00; bytes[4] = 8'h81;
    store(32'h1000_0008, 32'h0000_0001, 3'b010);
    exp_q.delete();
    exp_q.push_back(2'b10);
    for (int i = 0; i < 5; i++) add_frame(bytes[i], 1, i < 4);
    exp_q.push_back(2'b11);
    fork
      begin
        for (int i = 0; i < 5; i++) store(32'h1000_0000, {24'h0, bytes[i]}, 3'b000);
        read_reg(32'h1000_0004, d1);
        store(32'h1000_0000, 32'h0000_0099, 3'b000);
        read_reg(32'h1000_0004, d2);
      end
      begin
        @(posedge clk);
        #1;
        capture(exp_q.size());
      end
    join
    checks++;
    if (d1 !== 32'h0000_0405) begin
      failures++;
      $display("FAIL fifo_full_status: got %h expected %h", d1, 32'h0000_0405);
    end
    checks++;
    if (d2 !== 32'h0000_040D) begin
      failures++;
      $display("FAIL overflow_status: got %h expected %h", d2, 32'h0000_040D);
    end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL back_to_back_frames: sample %0d {tx,tx_idle}=%b expected %b",
               bad, cap_q[bad], exp_q[bad]);
    end
  endtask

  task automatic test_overflow_clear;
    logic [31:0] d;
    read_reg(32'h1000_0004, d);
    checks++;
    if (d !== 32'h0000_000A) begin
      failures++;
      $display("FAIL drained_status: got %h expected %h", d, 32'h0000_000A);
    end
    store(32'h1000_0004, 32'h0000_0008, 3'b010);
    read_reg(32'h1000_0004, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL overflow_clear: got %h expected %h", d, 32'h0000_0002);
    end
    read_reg(32'h1000_0008, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++;
      $display("FAIL divisor_kept: got %h expected %h", d, 32'h0000_0001);
    end
  endtask

  task automatic test_divisor;
    logic [31:0] d;
    int bad;
    store(32'h1000_0008, 32'h0000_0310, 3'b010);
    store(32'h1000_0009, 32'h0000_0002, 3'b000);
    read_reg(32'h1000_0008, d);
    checks++;
    if (d !== 32'h0000_0302) begin
      failures++;
      $display("FAIL divisor_byte: got %h expected %h", d, 32'h0000_0302);
    end
    store(32'h1000_0008, 32'hFFFF_ABCD, 3'b001);
    read_reg(32'h1000_0008, d);
    checks++;
    if (d !== 32'h0000_ABCD) begin
      failures++;
      $display("FAIL divisor_half: got %h expected %h", d, 32'h0000_ABCD);
    end
    store(32'h1000_0008, 32'h0000_0000, 3'b010);
    store(32'h1000_0000, 32'h0000_003C, 3'b000);
    exp_q.delete();
    exp_q.push_back(2'b10);
    add_frame(8'h3C, 1, 1'b0);
    exp_q.push_back(2'b11);
    capture(exp_q.size());
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL frame_div0: sample %0d {tx,tx_idle}=%b expected %b",
               bad, cap_q[bad], exp_q[bad]);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    int lows;
    store(32'h1000_0008, 32'h0000_0004, 3'b010);
    store(32'h1000_0000, 32'h0000_0011, 3'b000);
    store(32'h1000_0000, 32'h0000_0022, 3'b000);
    store(32'h1000_0000, 32'h0000_0033, 3'b000);
    repeat (5) @(posedge clk);
    #1;
    read_reg(32'h1000_0004, d);
    checks++;
    if (d !== 32'h0000_0204) begin
      failures++;
      $display("FAIL mid_frame_status: got %h expected %h", d, 32'h0000_0204);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({tx, tx_idle} !== 2'b11) begin
      failures++;
      $display("FAIL abort_lines: {tx,tx_idle}=%b expected 11", {tx, tx_idle});
    end
    read_reg(32'h1000_0004, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL abort_status: got %h expected %h", d, 32'h0000_0002);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    capture(60);
    lows = 0;
    for (int i = 0; i < cap_q.size(); i++) if (cap_q[i] !== 2'b11) lows++;
    checks++;
    if (lows != 0) begin
      failures++;
      $display("FAIL no_frame_after_reset: %0d non-idle samples expected 0", lows);
    end
  endtask

  task automatic test_decode;
    logic [31:0] d;
    read_reg(32'h1000_000C, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reserved_read: got %h expected 0", d);
    end
    read_reg(32'h2000_0004, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL outside_read: got %h expected 0", d);
    end
    read_reg(32'h1000_0007, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL low_bits_ignored: got %h expected %h", d, 32'h0000_0002);
    end
    store(32'h1000_000C, 32'hFFFF_FFFF, 3'b010);
    store(32'h2000_0000, 32'h0000_0077, 3'b000);
    read_reg(32'h1000_0008, d);
    checks++;
    if (d !== 32'h0000_0010) begin
      failures++;
      $display("FAIL reserved_write_ignored: divisor %h expected %h", d, 32'h0000_0010);
    end
    read_reg(32'h1000_0004, d);
    checks++;
    if (d !== 32'h0000_0002 || tx !== 1'b1) begin
      failures++;
      $display("FAIL outside_write_ignored: status %h tx %b expected 00000002 1", d, tx);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_back_to_back;
    test_overflow_clear;
    test_divisor;
    test_reset_mid_frame;
    test_decode;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as the responder on the CPU's data-memory port: write_enable, io_width, io_address, store data and load data.
- It sits beside the data cache. The top-level decoder steers accesses in its address window to it.
- Stores enqueue bytes into a small FIFO. A baud-rate FSM serializes them as 8N1 frames on tx.
- Loads return status and the divisor with the same combinational read timing as the data cache, so the single-cycle core needs no stalls.

Parameters:
- BASE_ADDR, 32'h1000_0000: window base. Only bits [31:4] are compared; the window is 16 bytes.
- FIFO_DEPTH, 4: TX FIFO entries. Must be a power of 2, at least 2.
- DEFAULT_DIVISOR, 16'd16: clocks per bit after reset.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- write_enable, input, 1: store strobe, sampled at posedge clk.
- io_width, input, 3: RISC-V funct3. 000 = byte, 001 = half, 010 = word. Other codes are treated as word.
- io_address, input, 32: byte address.
- data_in, input, 32: store data from the core.
- data_out, output, 32: load data, combinational.
- tx, output, 1: serial line; idles high.
- tx_idle, output, 1: high when the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Select: sel = (io_address[31:4] == BASE_ADDR[31:4]). Register offset = io_address[3:2]. Bits [1:0] are ignored.
- Register map:
  - Offset 0x0, TXDATA (write only, reads 0): a store with sel enqueues data_in[7:0] at any width.
  - Offset 0x4, STATUS (read):
    - bit0 full
    - bit1 empty
    - bit2 busy (FSM not IDLE)
    - bit3 overflow (sticky)
    - bits[15:8] FIFO count
    - all other bits 0
  - STATUS write: a store with data_in[3]=1 clears overflow. Other bits are ignored.
  - Offset 0x8, DIVISOR (R/W, bits [15:0]; upper bits read 0):
    - byte store writes [7:0] and keeps [15:8]
    - half or word store writes [15:0]
  - Offset 0xC: reserved. Reads 0; writes are ignored.
- data_out is 0 when sel=0. It is purely combinational from the current address and register state.
- Reset:
  - tx=1, FSM=IDLE, FIFO empty (pointers and count 0), overflow=0, DIVISOR=DEFAULT_DIVISOR.
  - Shift register, bit counter and baud counter are all 0.
  - Reset mid-frame aborts the frame; tx is high after that edge.
- FIFO:
  - A push to TXDATA is accepted only if count < FIFO_DEPTH before the edge.
  - A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle with count not full: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM (IDLE, START, DATA, STOP), one state register:
  - IDLE: tx=1. If the FIFO is non-empty at a posedge:
    - pop the head into shift[7:0]
    - latch bit_period = (DIVISOR==0) ? 1 : DIVISOR
    - clear the baud counter
    - go to START
  - START: tx=0 for bit_period clocks, then DATA with bit index 0.
  - DATA: tx=shift[0] for bit_period clocks. Then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for bit_period clocks, then IDLE. A queued byte is popped on the following edge, so there is exactly one extra idle-high clock between back-to-back frames.
- Baud counter: counts 0 to bit_period-1 and the bit advances at terminal count. A frame is exactly 10*bit_period clocks.
- Timing:
  - A DIVISOR write during a frame takes effect at the next frame start.
  - tx and tx_idle are registered (state-derived, glitch-free).
- Latency: a store to TXDATA at edge N into an empty FIFO in IDLE gives a pop at edge N+1; tx goes low after edge N+1.

Test Plan:
- Reset, then read 0x1000_0004 -> data_out=32'h0000_0002; tx=1; tx_idle=1. Read 0x1000_0008 -> 32'h0000_0010.
- SW 4 to 0x1000_0008, SB 0x55 to 0x1000_0000 -> tx low 1 cycle after the next edge, then bits 1,0,1,0,1,0,1,0, then stop 1. Each bit lasts exactly 4 clocks; the frame is 40 clocks, and tx_idle rises after the stop bit.
- Divisor 1: push 0xA5, 0x3C, 0xFF, 0x00, 0x81 back-to-back.
  - The first pops immediately.
  - The next four fill the FIFO; STATUS count=4, full=1.
  - A sixth push sets overflow=1 and is dropped.
  - tx shows 5 frames separated by 1 idle clock.
- Overflow clear: SW 32'h8 to 0x1000_0004 -> STATUS bit3=0; other state unchanged.
- SB 0x02 to 0x1000_0009 with DIVISOR=0x0310 -> DIVISOR=0x0302. Writing DIVISOR=0 then sending a byte -> 10-clock frame.
- Assert rst mid-DATA with 2 bytes queued -> tx=1, tx_idle=1, STATUS=0x2 on the next cycle; no further frames. Reads of 0x1000_000C and of 0x2000_0004 -> 0.
